// File: rtl/median_window_ctrl_pkg.sv
// Shared types for the median-window sequencer: FSM states and the
// per-strobe tag that travels alongside the filter pipeline.
package median_window_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Tag attached to every line-buffer strobe; describes the window centre.
  typedef struct packed {
    logic valid;
    logic border;
    logic hs;
    logic vs;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/median_window_ctrl_tag_delay.sv
// Enable-gated shift register: a word written at one enable leaves the
// output after DEPTH enables, so tags track the filter pipeline exactly.
module median_window_ctrl_tag_delay #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one position per enable; the last stage drives the output.
  // NOTE: every stage is reset, because a stale valid bit left in the chain
  // after a mid-frame reset would emit a phantom filter output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/median_window_ctrl.sv
// Sequencer in front of the 3x3 median filter and its line buffer.
// Counts strobes per frame, drives the line-buffer enable/data, tags each
// window centre as valid/border, and flushes the last row and the filter
// pipeline after the final pixel. Flush strobes keep advancing the same
// row/col counters so the centre arithmetic is identical for both kinds.
module median_window_ctrl
  import median_window_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int LAT   = 5,
  parameter int CNT_W = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_in_en,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic          lb_clken,
  output logic [DW-1:0] lb_data,
  output logic          out_valid,
  output logic          out_border,
  output logic          out_hs,
  output logic          out_vs,
  output logic          frame_done,
  output logic          busy,
  output logic          err_overrun
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] ROW_H    = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] ROW_H1   = CNT_W'(IMG_H + 1);
  // Number of flush strobes: one row plus one pixel to centre the final
  // window, plus LAT to drain the filter pipeline.
  localparam logic [CNT_W-1:0] FLUSH_N  = CNT_W'(IMG_W + 1 + LAT);

  state_t           state_q, state_d;
  logic             vs_d, vs_rise;
  logic [CNT_W-1:0] col_q, row_q, col_d, row_d;
  logic [CNT_W-1:0] cur_col, cur_row;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             accept, flush_stb, strobe, done_set, overrun;
  logic             c_valid, c_edge;
  tag_t             tag_d, tag_q, tag_out;

  assign vs_rise = vs_in & ~vs_d;
  assign strobe  = accept | flush_stb;
  assign busy    = (state_q != ST_IDLE);

  // Position of the current strobe; a frame start forces (0,0) so a pixel
  // arriving with vs_rise becomes the first pixel of the new frame.
  always_comb begin
    cur_col = vs_rise ? '0 : col_q;
    cur_row = vs_rise ? '0 : row_q;
  end

  // Next-state logic: strobe generation, counter advance, flush bookkeeping.
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    accept    = 1'b0;
    flush_stb = 1'b0;
    done_set  = 1'b0;
    overrun   = 1'b0;
    if (vs_rise) begin
      state_d = ST_FILL;
      flush_d = '0;
      accept  = pix_in_en;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_FILL: begin
          accept = pix_in_en;
          // Pixel IMG_W is the (IMG_W+1)-th: the first window centre exists.
          if (pix_in_en && cur_row == ONE && cur_col == '0) state_d = ST_RUN;
        end
        ST_RUN: begin
          accept = pix_in_en;
          if (pix_in_en && cur_row == ROW_LAST && cur_col == COL_LAST) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          overrun = pix_in_en;
          // One idle FLUSH cycle after the last strobe keeps the registered
          // lb_clken out of IDLE and lines frame_done up behind it.
          if (flush_q == FLUSH_N) begin
            state_d  = ST_IDLE;
            flush_d  = '0;
            done_set = 1'b1;
          end else begin
            flush_stb = 1'b1;
            flush_d   = flush_q + ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    col_d = cur_col;
    row_d = cur_row;
    if (accept || flush_stb) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + ONE;
      end else begin
        col_d = cur_col + ONE;
      end
    end
  end

  // Centre tag for this strobe. The centre trails the strobe by IMG_W+1
  // positions; at col 0 it wraps to the last column two rows up.
  always_comb begin
    tag_d = '0;
    if (cur_col == '0) begin
      c_valid = (cur_row >= TWO) && (cur_row <= ROW_H1);
      c_edge  = 1'b1 | (cur_row == TWO) | (cur_row == ROW_H1);
    end else begin
      c_valid = (cur_row >= ONE) && (cur_row <= ROW_H);
      c_edge  = (cur_col == ONE) | (cur_row == ONE) | (cur_row == ROW_H);
    end
    tag_d.valid  = c_valid;
    tag_d.border = c_valid & c_edge;
    tag_d.hs     = accept & hs_in;
    tag_d.vs     = accept & vs_in;
  end

  // Previous vs_in for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_d <= 1'b0;
    else        vs_d <= vs_in;
  end

  // FSM state, pixel position counters and flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      flush_q <= flush_d;
    end
  end

  // Registered line-buffer drive, tag entry and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_clken    <= 1'b0;
      lb_data     <= '0;
      tag_q       <= '0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      lb_clken    <= strobe;
      lb_data     <= accept ? pix_in : '0;
      tag_q       <= tag_d;
      frame_done  <= done_set;
      err_overrun <= overrun;
    end
  end

  median_window_ctrl_tag_delay #(
    .DEPTH(LAT),
    .WIDTH(TAG_W)
  ) u_tag_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (lb_clken),
    .d    (tag_q),
    .q    (tag_out)
  );

  assign out_valid  = tag_out.valid;
  assign out_border = tag_out.border;
  assign out_hs     = tag_out.hs;
  assign out_vs     = tag_out.vs;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl (IMG_W=8, IMG_H=4, LAT=5).
// Expected tags come from centre-index arithmetic (k - (W+1), div/mod).
module tb_median_window_ctrl;

  localparam int DW     = 8;
  localparam int W      = 8;
  localparam int H      = 4;
  localparam int LAT    = 5;
  localparam int CNT_W  = 12;
  localparam int NFLUSH = W + 1 + LAT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_in_en = 1'b0;
  logic          hs_in = 1'b0;
  logic          vs_in = 1'b0;
  logic          lb_clken, out_valid, out_border, out_hs, out_vs;
  logic          frame_done, busy, err_overrun;
  logic [DW-1:0] lb_data;

  median_window_ctrl #(
    .DW(DW), .IMG_W(W), .IMG_H(H), .LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_in_en(pix_in_en),
    .hs_in(hs_in), .vs_in(vs_in), .lb_clken(lb_clken), .lb_data(lb_data),
    .out_valid(out_valid), .out_border(out_border), .out_hs(out_hs),
    .out_vs(out_vs), .frame_done(frame_done), .busy(busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int fid; logic [DW-1:0] pix; logic hs; logic vs; } desc_t;
  typedef struct { logic v; logic b; logic h; logic s; int fid; } etag_t;

  desc_t      desc_q[$];
  etag_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         fid = 0;
  int         kk = 0;
  int         done_cnt = 0;
  int         ovr_cnt = 0;
  int         total_clk = 0;
  int         clk_by[8];
  int         valid_by[8];
  int         border_by[8];
  int         first_valid_k[8];
  logic [1:0] seq[8][64];
  logic       prev_clken = 1'b0;
  int         last_fid = 0;
  int         last_k = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Tag for the strobe at frame-linear index k: its window centre is k-(W+1).
  function automatic etag_t model_tag(input desc_t d);
    etag_t e;
    int c;
    c     = d.k - (W + 1);
    e.v   = (c >= 0) && (c < W * H);
    e.b   = 1'b0;
    if (e.v) e.b = (c / W == 0) || (c / W == H - 1) || (c % W == 0) || (c % W == W - 1);
    e.h   = d.hs;
    e.s   = d.vs;
    e.fid = d.fid;
    return e;
  endfunction

  // Per-cycle observation at the falling edge.
  task automatic mon();
    etag_t e;
    desc_t d;
    if (!rst_n) begin
      desc_q.delete();
      exp_q.delete();
      prev_clken = 1'b0;
      return;
    end
    e = '{1'b0, 1'b0, 1'b0, 1'b0, -1};
    if (exp_q.size() >= LAT) e = exp_q[exp_q.size() - LAT];
    check("out_valid", 32'(out_valid), 32'(e.v));
    check("out_border", 32'(out_border), 32'(e.b));
    check("out_hs", 32'(out_hs), 32'(e.h));
    check("out_vs", 32'(out_vs), 32'(e.s));
    if (prev_clken) begin
      if (out_valid && e.fid >= 0) valid_by[e.fid]++;
      if (out_border && e.fid >= 0) border_by[e.fid]++;
      if (out_valid && first_valid_k[last_fid] < 0) first_valid_k[last_fid] = last_k;
      if (last_k < 64) seq[last_fid][last_k] = {out_valid, out_border};
    end
    prev_clken = lb_clken;
    if (lb_clken) begin
      total_clk++;
      check("strobe_expected", 32'(desc_q.size() > 0), 32'd1);
      if (desc_q.size() > 0) begin
        d = desc_q.pop_front();
        check("lb_data", 32'(lb_data), 32'(d.pix));
        exp_q.push_back(model_tag(d));
        clk_by[d.fid]++;
        last_fid = d.fid;
        last_k   = d.k;
      end
    end
    if (frame_done) done_cnt++;
    if (err_overrun) ovr_cnt++;
  endtask

  task automatic cyc(input logic en, input logic [DW-1:0] p, input logic h, input logic v);
    pix_in_en = en;
    pix_in    = p;
    hs_in     = h;
    vs_in     = v;
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push_pix(input logic [DW-1:0] p, input logic h, input logic v);
    desc_q.push_back('{kk, fid, p, h, v});
    kk++;
  endtask

  task automatic start_frame(input bit with_pix);
    logic [DW-1:0] p;
    fid++;
    kk = 0;
    if (with_pix) begin
      p = DW'($urandom);
      push_pix(p, 1'b1, 1'b1);
      cyc(1'b1, p, 1'b1, 1'b1);
    end else begin
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
  endtask

  // Pixels first..last of the frame, each followed by `gap` idle cycles.
  task automatic send_pixels(input int first, input int last, input int gap);
    logic [DW-1:0] p;
    logic          h;
    for (int i = first; i <= last; i++) begin
      p = DW'($urandom);
      h = (i % W) == 0;
      push_pix(p, h, 1'b0);
      if (i == W * H - 1) for (int j = 0; j < NFLUSH; j++) push_pix('0, 1'b0, 1'b0);
      cyc(1'b1, p, h, 1'b0);
      idle(gap);
    end
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      idle(1);
      t++;
    end
    check("frame_done_timeout", 32'(done_cnt != d0), 32'd1);
    idle(8);
    check("frame_done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic frame_counts(input string name, input int f);
    check({name, "_clken"}, 32'(clk_by[f]), 32'd46);
    check({name, "_valid"}, 32'(valid_by[f]), 32'd32);
    check({name, "_border"}, 32'(border_by[f]), 32'd20);
  endtask

  initial begin
    int d0, o0, c0, f_full, f_old;
    for (int i = 0; i < 8; i++) first_valid_k[i] = -1;

    // Reset state and IDLE ignoring pixels.
    idle(3);
    check("reset_outputs", 32'({lb_clken, lb_data, out_valid, out_border, out_hs,
                                out_vs, frame_done, busy, err_overrun}), 32'd0);
    rst_n = 1'b1;
    c0 = total_clk;
    o0 = ovr_cnt;
    repeat (4) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    check("idle_no_clken", 32'(total_clk - c0), 32'd0);
    check("idle_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Full back-to-back frame.
    d0 = done_cnt;
    o0 = ovr_cnt;
    start_frame(1'b0);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_pixels(0, W * H - 1, 0);
    wait_done(d0);
    frame_counts("full", fid);
    check("full_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    f_full = fid;

    // Gapped input: one pixel every third cycle.
    d0 = done_cnt;
    start_frame(1'b0);
    send_pixels(0, W * H - 1, 2);
    wait_done(d0);
    frame_counts("gapped", fid);
    for (int k = 0; k < W * H + NFLUSH; k++)
      check($sformatf("gapped_seq_%0d", k), 32'(seq[fid][k]), 32'(seq[f_full][k]));

    // Overrun: a pixel offered during flush is dropped and flagged.
    d0 = done_cnt;
    o0 = ovr_cnt;
    start_frame(1'b0);
    send_pixels(0, W * H - 1, 0);
    idle(1);
    cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    wait_done(d0);
    check("overrun_pulse", 32'(ovr_cnt - o0), 32'd1);
    frame_counts("overrun", fid);

    // Restart after 10 pixels: aborted frame gives no frame_done.
    d0 = done_cnt;
    start_frame(1'b0);
    send_pixels(0, 9, 0);
    f_old = fid;
    start_frame(1'b0);
    send_pixels(0, W * H - 1, 0);
    wait_done(d0);
    check("restart_old_clken", 32'(clk_by[f_old]), 32'd10);
    check("restart_old_valid", 32'(valid_by[f_old]), 32'd1);
    frame_counts("restart", fid);

    // Reset mid-run.
    d0 = done_cnt;
    start_frame(1'b0);
    send_pixels(0, 11, 0);
    rst_n = 1'b0;
    idle(1);
    check("midrst_outputs", 32'({lb_clken, lb_data, out_valid, out_border, out_hs,
                                 out_vs, frame_done, busy, err_overrun}), 32'd0);
    rst_n = 1'b1;
    c0 = total_clk;
    repeat (5) cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    idle(20);
    check("midrst_no_clken", 32'(total_clk - c0), 32'd0);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);

    // vs_rise together with pix_in_en: that pixel is (0,0).
    d0 = done_cnt;
    start_frame(1'b1);
    send_pixels(1, W * H - 1, 0);
    wait_done(d0);
    frame_counts("samecyc", fid);
    // Tag entering on the 10th strobe (k=9) reaches the output LAT-1 strobes later.
    check("samecyc_first_valid", 32'(first_valid_k[fid]), 32'(9 + LAT - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
